// File: rtl/conv_sum_sched_pkg.sv
// conv_sum_sched_pkg
// Shared definitions for the layer sequencer:
//   - sched_state_e : FSM state encoding (also exported on dbg_state)
//   - descriptor bit-field offsets/widths inside the 64-bit descriptor word
//   - config word selectors and the packing function for w0/w1/w2
package conv_sum_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_SEND = 3'd3,
    S_RUN  = 3'd4,
    S_NEXT = 3'd5
  } sched_state_e;

  // Only the low 59 descriptor bits carry information; [63:59] are zero.
  localparam int DESC_USED_W = 59;

  localparam int IMG_W_LSB  = 0;
  localparam int IMG_W_W    = 12;
  localparam int IMG_H_LSB  = 12;
  localparam int IMG_H_W    = 12;
  localparam int CH_CYC_LSB = 24;
  localparam int CH_CYC_W   = 12;
  localparam int OCG_LSB    = 36;
  localparam int OCG_W      = 10;
  localparam int PERW_LSB   = 46;
  localparam int PERW_W     = 12;
  localparam int MODE_BIT   = 58;

  localparam logic [1:0] CFG_W0 = 2'd0;
  localparam logic [1:0] CFG_W1 = 2'd1;
  localparam logic [1:0] CFG_W2 = 2'd2;

  // Packs one of the three accumulator config words from a descriptor.
  function automatic logic [31:0] cfg_word(input logic [DESC_USED_W-1:0] d,
                                           input logic [1:0]             sel);
    logic [31:0] w;
    w = '0;
    case (sel)
      CFG_W0:  w = {8'b0, d[IMG_H_LSB +: IMG_H_W], d[IMG_W_LSB +: IMG_W_W]};
      CFG_W1:  w = {10'b0, d[OCG_LSB +: OCG_W], d[CH_CYC_LSB +: CH_CYC_W]};
      default: w = {19'b0, d[MODE_BIT], d[PERW_LSB +: PERW_W]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/conv_sum_desc_ram.sv
// conv_sum_desc_ram
// Per-layer descriptor table: one write port, one registered read port
// (read data appears the cycle after raddr is presented). Contents are
// not reset.
// Ports:
//   clk         clock
//   we          write strobe
//   waddr/wdata write index / data
//   raddr       read index
//   rdata       registered read data
module conv_sum_desc_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 59
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_sum_sched.sv
// conv_sum_sched
// Layer sequencer for the partial-sum accumulator. On start it walks
// layers 0..layer_num-1: reads the layer descriptor, computes the expected
// output-beat total, pushes three config words over the valid/ready config
// port, counts sum_valid beats to the total, then pulses layer_done
// (and all_done on the last layer).
//
// Optional feature macro: SCHED_WDOG_EN adds a WDOG_W-bit watchdog over
// SEND and RUN; on saturation it sets timeout and aborts to IDLE.
// Without it, timeout is tied 0.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   desc_we/addr/wdata         descriptor table write (accepted only in IDLE)
//   start, layer_num           sequence start pulse, layer count
//   m_cfg_valid/ready/data     config word output, valid/ready
//   sum_busy                   accumulator busy (not used for sequencing)
//   sum_valid                  accumulator output beat
//   layer_idx                  current layer
//   layer_done, all_done       completion pulses
//   sched_busy                 high outside IDLE
//   err                        sticky [0] zero-size layer, [1] stray sum_valid
//   timeout                    sticky watchdog flag
//   dbg_state                  current FSM state
//
// Config handshake: a word transfers on a cycle where m_cfg_valid and
// m_cfg_ready are both high at the clock edge. While valid is high and
// ready is low, m_cfg_data holds. valid never depends combinationally on
// ready; the next word is presented the cycle after a transfer.
module conv_sum_sched
  import conv_sum_sched_pkg::*;
#(
  parameter int MAX_LAYERS = 16,
  parameter int LAYER_W    = 4,
  parameter int CNT_W      = 32,
  parameter int WDOG_W     = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               desc_we,
  input  logic [LAYER_W-1:0] desc_addr,
  input  logic [63:0]        desc_wdata,
  input  logic               start,
  input  logic [LAYER_W:0]   layer_num,
  output logic               m_cfg_valid,
  input  logic               m_cfg_ready,
  output logic [31:0]        m_cfg_data,
  input  logic               sum_busy,
  input  logic               sum_valid,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               layer_done,
  output logic               all_done,
  output logic               sched_busy,
  output logic [1:0]         err,
  output logic               timeout,
  output logic [2:0]         dbg_state
);

  sched_state_e            state;
  logic [LAYER_W:0]        num_q;
  logic [CNT_W-1:0]        expected;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        beat_p1;
  logic [CNT_W-1:0]        prod;
  logic [1:0]              wsel;
  logic [DESC_USED_W-1:0]  desc_q;
  logic [DESC_USED_W-1:0]  rd_data;
  logic [LAYER_W:0]        idx_p1;
  logic                    last_layer;
  logic                    wdog_hit;

  assign sched_busy = (state != S_IDLE);
  assign dbg_state  = state;

  logic unused_ok;
  assign unused_ok = &{1'b0, sum_busy, desc_wdata[63:DESC_USED_W]};

  conv_sum_desc_ram #(
    .DEPTH (MAX_LAYERS),
    .AW    (LAYER_W),
    .DW    (DESC_USED_W)
  ) u_desc_ram (
    .clk   (clk),
    .we    (desc_we && (state == S_IDLE)),
    .waddr (desc_addr),
    .wdata (desc_wdata[DESC_USED_W-1:0]),
    .raddr (layer_idx),
    .rdata (rd_data)
  );

  always_comb begin
    prod = CNT_W'(rd_data[IMG_H_LSB +: IMG_H_W]) *
           CNT_W'(rd_data[IMG_W_LSB +: IMG_W_W]) *
           CNT_W'(rd_data[OCG_LSB +: OCG_W]);
    beat_p1    = beat_cnt + CNT_W'(1);
    idx_p1     = {1'b0, layer_idx} + {{LAYER_W{1'b0}}, 1'b1};
    last_layer = (idx_p1 == num_q);
  end

`ifdef SCHED_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_evt;
  logic              timeout_q;

  assign wdog_evt = (m_cfg_valid && m_cfg_ready) || sum_valid;
  assign wdog_hit = ((state == S_SEND) || (state == S_RUN)) && (&wdog_cnt) && !wdog_evt;
  assign timeout  = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state != S_SEND) && (state != S_RUN)) wdog_cnt <= '0;
      else if (wdog_evt)                        wdog_cnt <= '0;
      else if (!(&wdog_cnt))                    wdog_cnt <= wdog_cnt + WDOG_W'(1);
      if ((state == S_IDLE) && start) timeout_q <= 1'b0;
      if (wdog_hit)                   timeout_q <= 1'b1;
    end
  end
`else
  localparam int unused_wdog_w = WDOG_W;
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      num_q       <= '0;
      layer_idx   <= '0;
      expected    <= '0;
      beat_cnt    <= '0;
      wsel        <= CFG_W0;
      desc_q      <= '0;
      m_cfg_valid <= 1'b0;
      m_cfg_data  <= '0;
      layer_done  <= 1'b0;
      all_done    <= 1'b0;
      err         <= '0;
    end else begin
      layer_done <= 1'b0;
      all_done   <= 1'b0;
      // Beats are only meaningful while counting; anything else is stray.
      if (sum_valid && (state != S_RUN)) err[1] <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            err       <= '0;
            num_q     <= layer_num;
            layer_idx <= '0;
            if (layer_num == '0) all_done <= 1'b1;
            else                 state    <= S_LOAD;
          end
        end
        // Read address is layer_idx; data lands in rd_data for CALC.
        S_LOAD: state <= S_CALC;
        S_CALC: begin
          desc_q   <= rd_data;
          expected <= prod;
          beat_cnt <= '0;
          wsel     <= CFG_W0;
          if (prod == '0) begin
            err[0]     <= 1'b1;
            layer_done <= 1'b1;
            all_done   <= last_layer;
            state      <= S_NEXT;
          end else begin
            m_cfg_valid <= 1'b1;
            m_cfg_data  <= cfg_word(rd_data, CFG_W0);
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (m_cfg_ready) begin
            if (wsel == CFG_W2) begin
              m_cfg_valid <= 1'b0;
              state       <= S_RUN;
            end else begin
              wsel       <= wsel + 2'd1;
              m_cfg_data <= cfg_word(desc_q, wsel + 2'd1);
            end
          end
        end
        S_RUN: begin
          if (sum_valid) begin
            if (beat_p1 == expected) begin
              layer_done <= 1'b1;
              all_done   <= last_layer;
              state      <= S_NEXT;
            end else begin
              beat_cnt <= beat_p1;
            end
          end
        end
        // Done pulses were raised on entry, so they align with this state
        // and layer_idx still names the finished layer.
        S_NEXT: begin
          if (last_layer) begin
            state <= S_IDLE;
          end else begin
            layer_idx <= idx_p1[LAYER_W-1:0];
            state     <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (wdog_hit) begin
        layer_done  <= 1'b1;
        all_done    <= 1'b1;
        m_cfg_valid <= 1'b0;
        state       <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_conv_sum_sched.sv
// tb_conv_sum_sched
// Directed bench for conv_sum_sched. Config words and done pulses are
// predicted when stimulus is issued and pushed into queues; monitor
// processes pop and compare whenever the DUT presents a config transfer
// or a done pulse.
module tb_conv_sum_sched;

  localparam int LAYER_W = 4;
`ifdef SCHED_WDOG_EN
  localparam int WDOG_W = 4;
`else
  localparam int WDOG_W = 20;
`endif

  logic               clk;
  logic               rst_n;
  logic               desc_we;
  logic [LAYER_W-1:0] desc_addr;
  logic [63:0]        desc_wdata;
  logic               start;
  logic [LAYER_W:0]   layer_num;
  logic               m_cfg_valid;
  logic               m_cfg_ready;
  logic [31:0]        m_cfg_data;
  logic               sum_busy;
  logic               sum_valid;
  logic [LAYER_W-1:0] layer_idx;
  logic               layer_done;
  logic               all_done;
  logic               sched_busy;
  logic [1:0]         err;
  logic               timeout;
  logic [2:0]         dbg_state;

  conv_sum_sched #(
    .MAX_LAYERS (16),
    .LAYER_W    (LAYER_W),
    .CNT_W      (32),
    .WDOG_W     (WDOG_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .desc_we     (desc_we),
    .desc_addr   (desc_addr),
    .desc_wdata  (desc_wdata),
    .start       (start),
    .layer_num   (layer_num),
    .m_cfg_valid (m_cfg_valid),
    .m_cfg_ready (m_cfg_ready),
    .m_cfg_data  (m_cfg_data),
    .sum_busy    (sum_busy),
    .sum_valid   (sum_valid),
    .layer_idx   (layer_idx),
    .layer_done  (layer_done),
    .all_done    (all_done),
    .sched_busy  (sched_busy),
    .err         (err),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [5:0]  exp_done_q[$];   // {layer_done, all_done, layer_idx}
  int          n_vec;
  int          n_err;
  int          hs_cnt;
  logic        stall_q;
  logic [31:0] hold_data;
  logic        rdy_toggle;
  logic        rdy_level;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] dn(input logic ld, input logic ad, input logic [3:0] idx);
    return {ld, ad, idx};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_q && m_cfg_valid) check("cfg_hold", m_cfg_data, hold_data);
      if (m_cfg_valid && m_cfg_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL cfg_unexpected: got 0x%0h, expected no transfer", m_cfg_data);
        end else begin
          check("cfg_word", m_cfg_data, exp_q.pop_front());
        end
      end
      if (layer_done || all_done) begin
        if (exp_done_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL done_unexpected: got ld=%0b ad=%0b idx=%0d, expected none",
                   layer_done, all_done, layer_idx);
        end else begin
          check("done_pulse", {layer_done, all_done, layer_idx}, exp_done_q.pop_front());
        end
      end
    end
    stall_q   = rst_n && m_cfg_valid && !m_cfg_ready;
    hold_data = m_cfg_data;
  end

  // Accumulator config-ready model: steady level or toggling every cycle.
  always @(posedge clk) begin
    #1;
    if (rdy_toggle) m_cfg_ready = !m_cfg_ready;
    else            m_cfg_ready = rdy_level;
  end

  // ---------------- driver tasks ----------------
  task automatic write_desc(input logic [3:0] idx, input logic [11:0] h, input logic [11:0] w,
                            input logic [11:0] cc, input logic [9:0] oc,
                            input logic [11:0] pw, input logic mode);
    desc_we    = 1'b1;
    desc_addr  = idx;
    desc_wdata = {5'b0, mode, pw, oc, cc, h, w};
    @(posedge clk); #1;
    desc_we    = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] n);
    start     = 1'b1;
    layer_num = n;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    for (int k = 0; k < 200; k++) begin
      if (hs_cnt >= target) return;
      @(posedge clk); #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_hs: got %0d transfers, expected %0d", hs_cnt, target);
  endtask

  task automatic beats(input int n);
    sum_valid = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    sum_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!sched_busy) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: got sched_busy=1, expected 0 within %0d cycles", budget);
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_cfg_left"},  exp_q.size(),      0);
    check({tag, "_done_left"}, exp_done_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    n_vec = 0; n_err = 0; hs_cnt = 0;
    stall_q = 1'b0; hold_data = '0;
    rst_n = 1'b0; desc_we = 1'b0; desc_addr = '0; desc_wdata = '0;
    start = 1'b0; layer_num = '0; sum_busy = 1'b0; sum_valid = 1'b0;
    m_cfg_ready = 1'b1; rdy_toggle = 1'b0; rdy_level = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_valid", m_cfg_valid, 0);
    check("rst_data",  m_cfg_data,  0);
    check("rst_idx",   layer_idx,   0);
    check("rst_done",  {layer_done, all_done}, 0);
    check("rst_busy",  sched_busy,  0);
    check("rst_err",   err,         0);
    check("rst_tmo",   timeout,     0);

    // Case 1: single layer 2x3x4 = 24 beats; a desc write while busy is dropped.
    write_desc(4'd0, 12'd2, 12'd3, 12'd1, 10'd4, 12'd4, 1'b0);
    exp_q.push_back(32'h0000_2003);
    exp_q.push_back(32'h0000_4001);
    exp_q.push_back(32'h0000_0004);
    exp_done_q.push_back(dn(1'b1, 1'b1, 4'd0));
    base = hs_cnt;
    do_start(5'd1);
    wait_hs(base + 3);
    desc_we = 1'b1; desc_addr = 4'd0;
    desc_wdata = {5'b0, 1'b1, 12'hFFF, 10'd9, 12'd9, 12'd9, 12'd9};
    sum_valid = 1'b1;
    @(posedge clk); #1;
    desc_we = 1'b0;
    beats(23);
    wait_idle(50);
    check("c1_err", err, 2'b00);
    check_queues("c1");

    // Case 2: same descriptor (the busy write must not have landed), ready toggling.
    rdy_toggle = 1'b1;
    exp_q.push_back(32'h0000_2003);
    exp_q.push_back(32'h0000_4001);
    exp_q.push_back(32'h0000_0004);
    exp_done_q.push_back(dn(1'b1, 1'b1, 4'd0));
    base = hs_cnt;
    do_start(5'd1);
    wait_hs(base + 3);
    beats(24);
    wait_idle(50);
    rdy_toggle = 1'b0; rdy_level = 1'b1;
    check("c2_hs_count", hs_cnt - base, 3);
    check_queues("c2");

    // Case 3: three layers, totals 6, 1, 8, sum_valid held high throughout.
    write_desc(4'd0, 12'd2, 12'd3, 12'd1, 10'd1, 12'd4,   1'b0);
    write_desc(4'd1, 12'd1, 12'd1, 12'd2, 10'd1, 12'd7,   1'b1);
    write_desc(4'd2, 12'd2, 12'd2, 12'd3, 10'd2, 12'hABC, 1'b1);
    exp_q.push_back(32'h0000_2003); exp_q.push_back(32'h0000_1001); exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_1001); exp_q.push_back(32'h0000_1002); exp_q.push_back(32'h0000_1007);
    exp_q.push_back(32'h0000_2002); exp_q.push_back(32'h0000_2003); exp_q.push_back(32'h0000_1ABC);
    exp_done_q.push_back(dn(1'b1, 1'b0, 4'd0));
    exp_done_q.push_back(dn(1'b1, 1'b0, 4'd1));
    exp_done_q.push_back(dn(1'b1, 1'b1, 4'd2));
    sum_valid = 1'b1;
    do_start(5'd3);
    wait_idle(200);
    sum_valid = 1'b0;
    check("c3_err", err, 2'b10);
    check_queues("c3");

    // Case 4: middle layer has img_w=0 and is skipped without config.
    write_desc(4'd1, 12'd5, 12'd0, 12'd1, 10'd3, 12'd1, 1'b0);
    exp_q.push_back(32'h0000_2003); exp_q.push_back(32'h0000_1001); exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_2002); exp_q.push_back(32'h0000_2003); exp_q.push_back(32'h0000_1ABC);
    exp_done_q.push_back(dn(1'b1, 1'b0, 4'd0));
    exp_done_q.push_back(dn(1'b1, 1'b0, 4'd1));
    exp_done_q.push_back(dn(1'b1, 1'b1, 4'd2));
    base = hs_cnt;
    do_start(5'd3);
    check("c4_err_cleared", err, 2'b00);
    wait_hs(base + 3);
    beats(6);
    wait_hs(base + 6);
    beats(8);
    wait_idle(100);
    check("c4_err", err, 2'b01);
    check_queues("c4");

    // layer_num = 0: lone all_done, no config transfer.
    exp_done_q.push_back(dn(1'b0, 1'b1, 4'd0));
    base = hs_cnt;
    do_start(5'd0);
    repeat (3) @(posedge clk);
    #1;
    check("c4_zero_hs", hs_cnt - base, 0);
    check("c4_zero_busy", sched_busy, 0);
    check_queues("c4z");

    // Case 5: stray beat in IDLE, then reset during RUN.
    sum_valid = 1'b1;
    @(posedge clk); #1;
    sum_valid = 1'b0;
    @(posedge clk); #1;
    check("c5_stray_err", err, 2'b10);
    write_desc(4'd0, 12'd2, 12'd3, 12'd1, 10'd4, 12'd4, 1'b0);
    exp_q.push_back(32'h0000_2003);
    exp_q.push_back(32'h0000_4001);
    exp_q.push_back(32'h0000_0004);
    base = hs_cnt;
    do_start(5'd1);
    check("c5_err_cleared", err, 2'b00);
    wait_hs(base + 3);
    beats(5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("c5_rst_valid", m_cfg_valid, 0);
    check("c5_rst_busy",  sched_busy,  0);
    check("c5_rst_idx",   layer_idx,   0);
    check("c5_rst_done",  {layer_done, all_done}, 0);
    check("c5_rst_err",   err,         0);
    @(posedge clk); #1;
    check("c5_rst_valid2", m_cfg_valid, 0);
    check_queues("c5");

    // Descriptor write after reset is accepted: 1x1x1, mode=1.
    write_desc(4'd0, 12'd1, 12'd1, 12'd0, 10'd1, 12'd0, 1'b1);
    exp_q.push_back(32'h0000_1001);
    exp_q.push_back(32'h0000_1000);
    exp_q.push_back(32'h0000_1000);
    exp_done_q.push_back(dn(1'b1, 1'b1, 4'd0));
    base = hs_cnt;
    do_start(5'd1);
    wait_hs(base + 3);
    beats(1);
    wait_idle(50);
    check_queues("c5b");

`ifdef SCHED_WDOG_EN
    // Watchdog: config never accepted, so the sequencer must give up.
    rdy_level = 1'b0;
    @(posedge clk); #1;
    exp_done_q.push_back(dn(1'b1, 1'b1, 4'd0));
    do_start(5'd1);
    wait_idle(100);
    check("wd_timeout", timeout, 1);
    check("wd_valid", m_cfg_valid, 0);
    check_queues("wd");
    rdy_level = 1'b1;
    @(posedge clk); #1;
    do_start(5'd0);
    exp_done_q.push_back(dn(1'b0, 1'b1, 4'd0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wd_timeout_cleared", timeout, 0);
    check_queues("wd2");
`else
    check("tmo_tied", timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
